// File: rtl/sinegen8_pkg.sv
// sinegen8_pkg: shared definitions for the sinegen8 direct-digital sine source.
//   - default phase accumulator and divider widths
//   - MIDSCALE output code and quarter-wave table depth
//   - QLUT: 64-entry quarter-wave table, QLUT[i] = round(127*sin((i+0.5)*2*pi/256))
//   - sg_tag_t: per-stage pipeline tag (valid bit + quadrant)
//   - compose_sample(): folds a quadrant and a magnitude into an offset-binary code
package sinegen8_pkg;

  localparam int PHASE_W_DEFAULT = 16;
  localparam int DIV_W_DEFAULT   = 8;

  localparam logic [7:0] MIDSCALE   = 8'd128;
  localparam int         QLUT_DEPTH = 64;

  // Half-step sample offset keeps the table free of 0 and symmetric about
  // the quadrant boundaries, so mirroring the index is exact.
  localparam logic [6:0] QLUT [QLUT_DEPTH] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  typedef struct packed {
    logic       vld;
    logic [1:0] quad;
  } sg_tag_t;

  // Upper half of the cycle (quad 0-1) sits above midscale, lower half below.
  function automatic logic [7:0] compose_sample(input logic [1:0] quad,
                                                input logic [6:0] mag);
    if (quad[1]) begin
      return MIDSCALE - {1'b0, mag};
    end else begin
      return MIDSCALE + {1'b0, mag};
    end
  endfunction

endpackage

// File: rtl/sinegen8_qlut.sv
// sinegen8_qlut: registered 64x7 quarter-wave sine ROM (one cycle latency).
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset (clears the output register)
//   i_idx  - table address 0..63
//   o_q    - registered table value QLUT[i_idx], range 2..127
module sinegen8_qlut
  import sinegen8_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_idx,
  output logic [6:0] o_q
);

  logic [6:0] r_q;

  // Table read register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= 7'd0;
    end else begin
      r_q <= QLUT[i_idx];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sinegen8.sv
// sinegen8: direct-digital sine sample source feeding an 8-bit PRS comparator.
// A phase accumulator advances by i_ftw once per (i_div+1) enabled cycles; the
// top 8 phase bits drive a 3-stage pipeline (quadrant fold, quarter-wave ROM,
// offset-binary compose). The sample is held between o_valid pulses.
// Ports:
//   i_clk     - clock, all state on rising edge
//   i_rst     - synchronous active-high reset
//   i_en      - run enable; low freezes divider and phase (pipeline still drains)
//   i_ftw     - frequency tuning word, used only on strobe cycles
//   i_div     - sample period minus one, in clk cycles
//   i_amp     - amplitude scale (only when SINEGEN8_AMP_EN is defined)
//   o_compare - offset-binary sine sample, 1..255, midscale 128 after reset
//   o_valid   - one-cycle pulse when o_compare takes a new value
// Build option: define SINEGEN8_AMP_EN to add i_amp and scale the output by
// (q*amp)>>8; without it the full-scale table value is used.
module sinegen8
  import sinegen8_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEFAULT,
  parameter int DIV_W   = DIV_W_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [PHASE_W-1:0] i_ftw,
  input  logic [DIV_W-1:0]   i_div,
`ifdef SINEGEN8_AMP_EN
  input  logic [7:0]         i_amp,
`endif
  output logic [7:0]         o_compare,
  output logic               o_valid
);

  logic [DIV_W-1:0]   r_cnt;
  logic [PHASE_W-1:0] r_phase;
  logic               w_strobe;
  logic [7:0]         w_ptop;
  logic [5:0]         w_idx;

  sg_tag_t            r_s1_tag;
  logic [5:0]         r_s1_idx;
  sg_tag_t            r_s2_tag;
  logic [6:0]         w_s2_q;
  logic [6:0]         w_mag;

  logic [7:0]         r_compare;
  logic               r_valid;

  // Strobe detect and stage-1 quadrant fold of the pre-update phase.
  always_comb begin
    w_strobe = i_en && (r_cnt == i_div);
    w_ptop   = r_phase[PHASE_W-1 -: 8];
    // Quads 1 and 3 run the quarter wave backwards: 63-idx is ~idx in 6 bits.
    if (w_ptop[6]) begin
      w_idx = ~w_ptop[5:0];
    end else begin
      w_idx = w_ptop[5:0];
    end
  end

  // Sample-period divider and phase accumulator.
  // Lowering i_div below r_cnt simply lets r_cnt wrap through its full range.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= {DIV_W{1'b0}};
      r_phase <= {PHASE_W{1'b0}};
    end else if (w_strobe) begin
      r_cnt   <= {DIV_W{1'b0}};
      r_phase <= r_phase + i_ftw;
    end else if (i_en) begin
      r_cnt   <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt   <= r_cnt;
      r_phase <= r_phase;
    end
  end

  // Stage 1 register: folded table index plus tag; runs regardless of i_en.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_tag.vld  <= 1'b0;
      r_s1_tag.quad <= 2'd0;
      r_s1_idx      <= 6'd0;
    end else begin
      r_s1_tag.vld  <= w_strobe;
      r_s1_tag.quad <= w_ptop[7:6];
      r_s1_idx      <= w_idx;
    end
  end

  sinegen8_qlut u_qlut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_idx (r_s1_idx),
    .o_q   (w_s2_q)
  );

  // Stage 2 tag register, aligned with the ROM output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_tag.vld  <= 1'b0;
      r_s2_tag.quad <= 2'd0;
    end else begin
      r_s2_tag <= r_s1_tag;
    end
  end

`ifdef SINEGEN8_AMP_EN
  // Amplitude scaling: 7x8 unsigned product, keep bits [14:8].
  always_comb begin
    w_mag = 7'(({8'd0, w_s2_q} * {7'd0, i_amp}) >> 8);
  end
`else
  // Full-scale magnitude straight from the table.
  always_comb begin
    w_mag = w_s2_q;
  end
`endif

  // Stage 3 output register: new sample on a valid tag, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_compare <= MIDSCALE;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= r_s2_tag.vld;
      if (r_s2_tag.vld) begin
        r_compare <= compose_sample(r_s2_tag.quad, w_mag);
      end else begin
        r_compare <= r_compare;
      end
    end
  end

  assign o_compare = r_compare;
  assign o_valid   = r_valid;

endmodule

// File: tb/tb_sinegen8.sv
// tb_sinegen8: scoreboard bench for sinegen8. The stimulus process pushes the
// hand-computed sample expected for each strobe cycle, tagged with the cycle in
// which it must appear (strobe + 3). A monitor on the falling edge pops and
// compares on that cycle, and otherwise checks that o_valid is low and that
// o_compare holds the last sample (128 after reset).
module tb_sinegen8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] ftw = 16'h0000;
  logic [7:0]  div = 8'd0;
`ifdef SINEGEN8_AMP_EN
  logic [7:0]  amp = 8'd0;
`endif
  logic [7:0]  compare;
  logic        valid;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  vals[$];
  exp_t        mon_e;
  int          cyc      = 0;
  logic        rst_q    = 1'b0;
  bit          mon_en   = 1'b0;
  logic [7:0]  last_val = 8'd128;
  int          total    = 0;
  int          bad      = 0;

  sinegen8 dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_ftw     (ftw),
    .i_div     (div),
`ifdef SINEGEN8_AMP_EN
    .i_amp     (amp),
`endif
    .o_compare (compare),
    .o_valid   (valid)
  );

  always #5 clk = ~clk;

  // Cycle counter and registered copy of reset, both on the active edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        // Reset edge just passed: in-flight samples are dropped.
        mon_en   = 1'b1;
        last_val = 8'd128;
        while (sb.size() > 0 && sb[0].cyc < cyc + 3) begin
          void'(sb.pop_front());
        end
      end
      if (mon_en) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          mon_e = sb.pop_front();
          check("valid_pulse", int'(valid), 1);
          check("sample", int'(compare), int'(mon_e.val));
          last_val = mon_e.val;
        end else begin
          check("valid_idle", int'(valid), 0);
          check("hold", int'(compare), int'(last_val));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue n expected samples cycling through a, b, c, d.
  task automatic plan(input int n, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] p [4];
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
    for (int i = 0; i < n; i++) begin
      vals.push_back(p[i % 4]);
    end
  endtask

  // Run n cycles; strobes are expected at cycle 'first' and every 'period' after.
  task automatic run(input int n, input int first, input int period);
    int   nxt;
    exp_t e;
    nxt = first;
    for (int c = 0; c < n; c++) begin
      if (c == nxt) begin
        e.cyc = cyc + 3;
        e.val = vals.pop_front();
        sb.push_back(e);
        nxt += period;
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) step();
`ifdef SINEGEN8_AMP_EN
    en = 1'b1; div = 8'd0; ftw = 16'h4000;
    amp = 8'd0;
    do_reset();
    plan(8, 8'd128, 8'd128, 8'd128, 8'd128);
    run(8, 0, 1);
    amp = 8'd128;
    do_reset();
    plan(8, 8'd129, 8'd191, 8'd127, 8'd65);
    run(8, 0, 1);
`else
    // Back-to-back samples at div=0, quarter-cycle step.
    en = 1'b1; div = 8'd0; ftw = 16'h4000;
    do_reset();
    plan(12, 8'd130, 8'd255, 8'd126, 8'd1);
    run(12, 0, 1);
    // div=3: one sample per 4 cycles, first strobe at cycle 3.
    div = 8'd3;
    do_reset();
    plan(3, 8'd130, 8'd255, 8'd126, 8'd0);
    run(14, 3, 4);
    // Enable low for 10 cycles with cnt parked at 2, then resume.
    en = 1'b0;
    run(10, -1, 4);
    en = 1'b1;
    plan(3, 8'd1, 8'd130, 8'd255, 8'd0);
    run(10, 1, 4);
    // Tuning word doubled mid-period (cnt=0, phase 0x8000).
    ftw = 16'h8000;
    plan(4, 8'd126, 8'd130, 8'd126, 8'd130);
    run(16, 3, 4);
    // Reset with samples in flight: they must never appear.
    div = 8'd0; ftw = 16'h4000;
    plan(2, 8'd126, 8'd1, 8'd0, 8'd0);
    run(2, 0, 1);
    do_reset();
    plan(8, 8'd130, 8'd255, 8'd126, 8'd1);
    run(8, 0, 1);
    // div lowered below cnt (2 -> div 1): cnt wraps through 255 first.
    div = 8'd3;
    do_reset();
    plan(1, 8'd130, 8'd0, 8'd0, 8'd0);
    run(6, 3, 4);
    div = 8'd1;
    plan(3, 8'd255, 8'd126, 8'd1, 8'd0);
    run(260, 255, 2);
`endif
    en = 1'b0;
    repeat (6) step();
    check("drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time limit in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sinegen8.md
# sinegen8

Direct-digital sine sample source that drives the 8-bit `compare` input of the pseudo-random-sequence bitstream generator in the prssine example. A phase accumulator advances by a frequency tuning word once per programmable sample period. The top 8 phase bits address a quarter-wave table. The result is an unsigned offset-binary 8-bit sample held stable for a whole sample period, so the downstream PRS comparator averages it into a sine-modulated bitstream.

## Interface
- `PHASE_W`, 16: phase accumulator and tuning word width (≥ 8).
- `DIV_W`, 8: sample-period divider width.
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable. Low freezes the divider and phase.
- `ftw` in `PHASE_W`: frequency tuning word, sampled only on a strobe cycle.
- `div` in `DIV_W`: sample period minus one, in clk cycles. Sampled continuously.
- `compare` out [8:1]: sine sample, offset binary; connects to the PRS generator `compare`.
- `valid` out 1: one-cycle pulse in the cycle `compare` takes a new value.
- `amp` in [8:1]: amplitude scale. Present only with `SINEGEN8_AMP_EN`.

## Operation
- Divider `cnt` (`DIV_W` bits) increments in each cycle with `en` high.
  - Strobe cycle S is a cycle where `en` is high and `cnt == div`; `cnt` then returns to 0.
  - `div = 0` gives a strobe in every enabled cycle.
  - If `div` is lowered below the current `cnt`, `cnt` counts up and wraps through the full `DIV_W` range before the next strobe. No special case is applied.
- On a strobe:
  - `phase <= phase + ftw`, modulo 2^`PHASE_W`.
  - The pre-update top 8 phase bits P[7:0] enter the pipeline.
- Stage 1: quad = P[7:6], idx = P[5:0]. For quad 1 and quad 3, idx is replaced by 63 − idx.
- Stage 2: q = QLUT[idx], where QLUT[i] = round(127·sin((i+0.5)·2π/256)).
  - Range is 2..127; QLUT[0] = 2 and QLUT[63] = 127.
- Stage 3: `compare` = 128 + q for quad 0–1, and 128 − q for quad 2–3.
  - Output range is 1..255 and never 0.
  - `valid` pulses in this stage.
- The pipeline advances every cycle independently of `en`. A strobe issued just before `en` falls still completes.
- `compare` holds its value between `valid` pulses.
- Reset values:
  - `phase` = 0, `cnt` = 0.
  - Pipeline valid bits cleared.
  - `compare` = 8'd128 (midscale), `valid` = 0.
- Reset mid-operation discards in-flight samples. `compare` reads 128 in the cycle after the reset edge.

## Timing
- Latency: strobe in cycle S → new `compare` and `valid` = 1 visible in cycle S+3.
- Throughput: one sample per `div`+1 enabled cycles. Back-to-back at `div = 0`.
- First strobe after reset with `en` held high: cycle `div` (cycles numbered from 0 after reset release). First sample is for phase 0 and equals 130.
- A `ftw` change takes effect at the next strobe, never mid-period.
- `en` low: no strobes, `cnt` and `phase` hold, no `valid` pulses once the pipeline has drained.

## Configuration
- `SINEGEN8_AMP_EN` defined:
  - The `amp` port exists.
  - Stage 3 uses qs = (q·amp) >> 8, an unsigned 15-bit product, truncated.
  - Output is 128 ± qs. `amp = 0` gives constant 128.
  - Latency is unchanged.
- Undefined: no `amp` port. Full-scale table value is used.

## Structure
- Shared package `sinegen8_pkg`:
  - Default `PHASE_W` and `DIV_W`.
  - `MIDSCALE` = 8'd128.
  - `QLUT_DEPTH` = 64.
  - The 64-entry QLUT constant array.
- One sub-module, `sinegen8_qlut`: registered 64×7 quarter-wave ROM implementing stage 2. It is reusable by other sine sources.

## Test plan
- `div = 0`, `ftw = 16'h4000`, `en = 1` → `compare` sequence 130, 255, 126, 1 repeating, with `valid` high in every cycle from cycle 3 on.
- `div = 3`, `ftw = 16'h4000` → `valid` pulses every 4 cycles; `compare` holds each value for 4 cycles.
- `en` dropped for 10 cycles mid-run → no new samples and `compare` frozen. On resume, the sequence continues from the held phase with no skipped or repeated sample.
- `ftw` changed from 16'h4000 to 16'h8000 between strobes → the next sample still uses the old step, then alternates 130/126.
- `rst` pulsed mid-run → `compare = 128` and `valid = 0` next cycle; the first sample after release is 130.
- With `SINEGEN8_AMP_EN`, `ftw = 16'h4000`:
  - `amp = 0` → constant 128.
  - `amp = 128` → sequence 129, 191, 127, 65.
